// File: rtl/serial_paralelo_rx.sv
// Purpose : per-lane receive deserializer; hunts for COM alignment, then emits one aligned byte every 8 bits.
// Latency : byte whose last bit is sampled at edge E appears on data_out/valid_out/byte_strobe at E+1; active likewise at E+1 after the final COM.
// Backpressure: none; the serial stream is consumed every cycle and each byte is presented for a single strobe cycle.
//
// Ports:
//   clk_32f     in   bit clock, all logic on its rising edge
//   reset       in   asynchronous, active-high reset
//   data_in     in   serial bit, MSB of each byte first
//   data_out    out  [7:0] last aligned byte captured while ACTIVE
//   valid_out   out  1 when data_out is payload (neither COM nor IDL)
//   byte_strobe out  one-cycle pulse whenever data_out/valid_out update
//   active      out  lane aligned and delivering bytes

module serial_paralelo_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter logic [7:0]  IDL       = 8'h7C,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    state_t     state;
    state_t     state_d;
    logic [7:0] sr;
    logic [2:0] bit_cnt;
    logic [2:0] bit_cnt_d;
    logic [3:0] com_cnt;
    logic [3:0] com_cnt_d;
    logic [3:0] com_cnt_inc;
    logic [7:0] data_out_d;
    logic       valid_out_d;
    logic       byte_strobe_d;
    logic       sr_is_com;
    logic       at_boundary;

    // Serial shift register: sr always holds the last 8 sampled bits,
    // newest bit in sr[0], so a full byte sent MSB first lands in order.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sr <= 8'h00;
        end else begin
            sr <= {sr[6:0], data_in};
        end
    end

    assign sr_is_com   = (sr == COM);
    assign com_cnt_inc = com_cnt + 4'd1;

    // bit_cnt is cleared on the edge that accepts the first COM, one edge
    // after that COM completed in sr. It therefore reads 7 exactly when sr
    // holds a complete byte on the 8-bit grid anchored at that COM.
    assign at_boundary = (bit_cnt == 3'd7);

    always_comb begin
        state_d       = state;
        bit_cnt_d     = bit_cnt;
        com_cnt_d     = com_cnt;
        data_out_d    = data_out;
        valid_out_d   = valid_out;
        byte_strobe_d = 1'b0;

        case (state)
            SEARCH: begin
                // Bit-slip hunting: every offset is a candidate.
                bit_cnt_d = 3'd0;
                com_cnt_d = 4'd0;
                if (sr_is_com) begin
                    com_cnt_d = 4'd1;
                    state_d   = (COM_TARGET == 4'd1) ? ACTIVE : LOCK;
                end
            end

            LOCK: begin
                bit_cnt_d = bit_cnt + 3'd1;
                // Off-grid COM patterns are ignored while confirming alignment.
                if (at_boundary) begin
                    if (sr_is_com) begin
                        com_cnt_d = com_cnt_inc;
                        if (com_cnt_inc == COM_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        // The failing byte is not re-examined as a fresh
                        // anchor; hunting restarts with the next window.
                        state_d   = SEARCH;
                        com_cnt_d = 4'd0;
                        bit_cnt_d = 3'd0;
                    end
                end
            end

            ACTIVE: begin
                // Sticky: only reset leaves ACTIVE.
                bit_cnt_d = bit_cnt + 3'd1;
                if (at_boundary) begin
                    data_out_d    = sr;
                    valid_out_d   = (sr != COM) && (sr != IDL);
                    byte_strobe_d = 1'b1;
                end
            end

            default: begin
                state_d   = SEARCH;
                bit_cnt_d = 3'd0;
                com_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out    <= 8'h00;
            valid_out   <= 1'b0;
            byte_strobe <= 1'b0;
            active      <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            com_cnt     <= com_cnt_d;
            data_out    <= data_out_d;
            valid_out   <= valid_out_d;
            byte_strobe <= byte_strobe_d;
            // Registered alongside the state so it rises on the same edge
            // that enters ACTIVE.
            active      <= (state_d == ACTIVE);
        end
    end

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Purpose : self-checking bench for serial_paralelo_rx (default COM_COUNT and COM_COUNT=1 instances).
// Latency : outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; one bit is driven per clock.

module tb_serial_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out0;
    logic       valid_out0;
    logic       byte_strobe0;
    logic       active0;
    logic [7:0] data_out1;
    logic       valid_out1;
    logic       byte_strobe1;
    logic       active1;

    serial_paralelo_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out0),
        .valid_out   (valid_out0),
        .byte_strobe (byte_strobe0),
        .active      (active0)
    );

    serial_paralelo_rx #(.COM_COUNT(1)) dut1 (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out1),
        .valid_out   (valid_out1),
        .byte_strobe (byte_strobe1),
        .active      (active1)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    int total;
    int bad;

    // Reference model: alignment expressed as an anchor edge number plus
    // a COM run length; boundaries are edges whose distance from the
    // anchor is a positive multiple of 8.
    int         edge_n;
    logic [7:0] win;
    int         cc_m   [2];
    int         anchor [2];
    int         run_m  [2];
    bit         act_m  [2];
    logic [7:0] dat_m  [2];
    bit         val_m  [2];
    bit         stb_m  [2];

    typedef struct {
        logic [7:0] b;
        logic       e_active;
        logic [7:0] e_data;
        logic       e_valid;
        logic       e_strobe;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        win    = 8'h00;
        for (int k = 0; k < 2; k++) begin
            anchor[k] = -1;
            run_m[k]  = 0;
            act_m[k]  = 1'b0;
            dat_m[k]  = 8'h00;
            val_m[k]  = 1'b0;
            stb_m[k]  = 1'b0;
        end
    endtask

    // win holds the bits sampled up to edge_n-1 when this runs.
    task automatic model_edge(input int k);
        stb_m[k] = 1'b0;
        if (anchor[k] < 0) begin
            if (win == COM) begin
                anchor[k] = edge_n - 1;
                run_m[k]  = 1;
                if (run_m[k] >= cc_m[k]) act_m[k] = 1'b1;
            end
        end else if (((edge_n - 1 - anchor[k]) % 8) == 0) begin
            if (act_m[k]) begin
                dat_m[k] = win;
                val_m[k] = (win != COM) && (win != IDL);
                stb_m[k] = 1'b1;
            end else if (win == COM) begin
                run_m[k]++;
                if (run_m[k] >= cc_m[k]) act_m[k] = 1'b1;
            end else begin
                anchor[k] = -1;
                run_m[k]  = 0;
            end
        end
    endtask

    task automatic model_compare();
        chk($sformatf("m0.data e%0d", edge_n), data_out0, dat_m[0]);
        chk($sformatf("m0.valid e%0d", edge_n), {7'd0, valid_out0}, {7'd0, val_m[0]});
        chk($sformatf("m0.strobe e%0d", edge_n), {7'd0, byte_strobe0}, {7'd0, stb_m[0]});
        chk($sformatf("m0.active e%0d", edge_n), {7'd0, active0}, {7'd0, act_m[0]});
        chk($sformatf("m1.data e%0d", edge_n), data_out1, dat_m[1]);
        chk($sformatf("m1.valid e%0d", edge_n), {7'd0, valid_out1}, {7'd0, val_m[1]});
        chk($sformatf("m1.strobe e%0d", edge_n), {7'd0, byte_strobe1}, {7'd0, stb_m[1]});
        chk($sformatf("m1.active e%0d", edge_n), {7'd0, active1}, {7'd0, act_m[1]});
    endtask

    // Drive one bit, clock it in, advance the model and compare both lanes.
    task automatic step(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
        edge_n++;
        for (int k = 0; k < 2; k++) model_edge(k);
        win = {win[6:0], b};
        model_compare();
    endtask

    task automatic send_byte(input logic [7:0] byt);
        for (int j = 7; j >= 0; j--) step(byt[j]);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst.data0", data_out0, 8'h00);
        chk("rst.valid0", {7'd0, valid_out0}, 8'h00);
        chk("rst.strobe0", {7'd0, byte_strobe0}, 8'h00);
        chk("rst.active0", {7'd0, active0}, 8'h00);
        chk("rst.active1", {7'd0, active1}, 8'h00);
        chk("rst.data1", data_out1, 8'h00);
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    function automatic vec_t mk(input logic [7:0] b, input logic a, input logic [7:0] d,
                                input logic v, input logic s);
        vec_t r;
        r.b        = b;
        r.e_active = a;
        r.e_data   = d;
        r.e_valid  = v;
        r.e_strobe = s;
        return r;
    endfunction

    task automatic check_vec(input int i);
        vec_t r;
        r = tbl[i];
        chk($sformatf("tbl%0d.active", i), {7'd0, active0}, {7'd0, r.e_active});
        chk($sformatf("tbl%0d.data", i), data_out0, r.e_data);
        chk($sformatf("tbl%0d.valid", i), {7'd0, valid_out0}, {7'd0, r.e_valid});
        chk($sformatf("tbl%0d.strobe", i), {7'd0, byte_strobe0}, {7'd0, r.e_strobe});
    endtask

    // Each entry's expectations are checked on the edge after its last bit.
    task automatic run_table();
        vec_t cur;
        for (int i = 0; i < tbl.size(); i++) begin
            cur = tbl[i];
            for (int j = 7; j >= 0; j--) begin
                step(cur.b[j]);
                if (j == 7 && i > 0) check_vec(i - 1);
            end
        end
        step(1'b0);
        check_vec(tbl.size() - 1);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cc_m[0]  = 4;
        cc_m[1]  = 1;
        reset    = 1'b1;
        data_in  = 1'b0;
        model_reset();
        @(posedge clk_32f);
        #1;

        // Lock on 4 COMs from reset, then a payload byte and an idle.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b1, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1));
        tbl.push_back(mk(IDL,   1'b1, 8'h7C, 1'b0, 1'b1));
        run_table();
        step(1'b0);
        chk("strobe_single_cycle", {7'd0, byte_strobe0}, 8'h00);
        chk("data_holds", data_out0, 8'h7C);

        // Lock at a 3-bit offset.
        do_reset();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        tbl.delete();
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b1, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h3C, 1'b1, 8'h3C, 1'b1, 1'b1));
        run_table();

        // Broken COM run falls back to SEARCH; a fresh full run is needed.
        do_reset();
        tbl.delete();
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h55, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(COM,   1'b1, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1));
        run_table();

        // Mid-byte reset while ACTIVE, then COM-free data never locks.
        step(1'b1);
        step(1'b1);
        chk("pre_reset_active", {7'd0, active0}, 8'h01);
        do_reset();
        tbl.delete();
        tbl.push_back(mk(8'h11, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h22, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h33, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h44, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'hA5, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        run_table();
        chk("no_com_lane1_inactive", {7'd0, active1}, 8'h00);

        // COM_COUNT=1: a single COM is enough.
        do_reset();
        for (int j = 7; j >= 1; j--) step(COM[j]);
        step(COM[0]);
        chk("cc1.active_before", {7'd0, active1}, 8'h00);
        step(1'b1);
        chk("cc1.active_after_com", {7'd0, active1}, 8'h01);
        chk("cc1.strobe_idle", {7'd0, byte_strobe1}, 8'h00);
        for (int j = 0; j < 7; j++) step(1'b1);
        step(1'b0);
        chk("cc1.data_ff", data_out1, 8'hFF);
        chk("cc1.valid_ff", {7'd0, valid_out1}, 8'h01);
        chk("cc1.strobe_ff", {7'd0, byte_strobe1}, 8'h01);

        // Randomized segments of garbage, COM runs and payload, checked
        // every cycle against the model.
        do_reset();
        for (int seg = 0; seg < 60; seg++) begin
            int n_garb;
            int n_com;
            int n_pay;
            logic [7:0] pb;
            if ($urandom_range(0, 9) == 0) do_reset();
            n_garb = $urandom_range(0, 7);
            for (int j = 0; j < n_garb; j++) step(1'($urandom_range(0, 1)));
            n_com = $urandom_range(0, 5);
            for (int j = 0; j < n_com; j++) send_byte(COM);
            n_pay = $urandom_range(1, 8);
            for (int j = 0; j < n_pay; j++) begin
                case ($urandom_range(0, 5))
                    0:       pb = IDL;
                    1:       pb = COM;
                    default: pb = 8'($urandom_range(0, 255));
                endcase
                send_byte(pb);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Per-lane receive deserializer sitting directly downstream of the lane serializer inside the phy.
- Consumes the serial bitstream on clk_32f (MSB first) and acquires byte alignment by hunting for COM symbols.
- Declares the lane active after a programmable run of aligned COMs.
- Then emits one byte every 8 bits, with a one-cycle strobe and a valid flag that masks COM/IDL fill symbols.

Parameters:
COM, 8'hBC, comma/alignment symbol.
IDL, 8'h7C, idle fill symbol, sent by the TX when its valid_in is low.
COM_COUNT, 4, consecutive aligned COMs required to enter ACTIVE (legal range 1..15).

Ports:
clk_32f  input  1  bit clock. Single clock domain; all logic on its rising edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  1  serial bit, MSB of each byte first.
data_out  output  8  last aligned byte captured in ACTIVE.
valid_out  output  1  1 when data_out holds a payload byte (not COM, not IDL).
byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
active  output  1  lane aligned and delivering bytes.

Behaviour:
- Shift register: sr[7:0] <= {sr[6:0], data_in} every cycle; sr is the last 8 bits sampled.
- State machine: SEARCH, LOCK, ACTIVE (registered). Internal signals:
  - bit_cnt: 3 bits.
  - com_cnt: 4 bits, saturating at COM_COUNT.
- Reset (asynchronous, any time, including mid-byte):
  - state=SEARCH; sr, bit_cnt, com_cnt = 0.
  - data_out=8'h00; valid_out=0; byte_strobe=0; active=0.
  - Re-acquisition always needs a full COM_COUNT run.
- Boundary definition:
  - Let E0 be the edge after which sr==COM while in SEARCH.
  - Boundaries are the sr contents after edges E0+8k, k>=1.
  - Each boundary is evaluated on the following edge.
- SEARCH:
  - sr is checked every cycle, at any bit offset (bit-slip hunting).
  - On sr==COM: next edge sets state=LOCK, com_cnt=1, bit_cnt=0.
  - If COM_COUNT==1, go straight to ACTIVE instead of LOCK.
- LOCK:
  - bit_cnt increments each cycle (mod 8); sr is examined only at boundaries.
  - Boundary sr==COM: com_cnt+1. When it reaches COM_COUNT, go to ACTIVE on that same edge.
  - Boundary sr!=COM: go to SEARCH, com_cnt=0. That boundary byte itself is not re-tested as a new E0; hunting resumes on the next cycle.
  - Non-boundary cycles: sr content is ignored even if it equals COM.
- ACTIVE (sticky until reset; no loss-of-sync detection in this block):
  - At each boundary, on the next edge:
    - data_out<=sr.
    - valid_out<=(sr!=COM && sr!=IDL).
    - byte_strobe<=1.
  - Otherwise byte_strobe<=0, and data_out/valid_out hold.
  - COM and IDL bytes still produce a strobe, with valid_out=0.
- active output = registered (state==ACTIVE).
- Latency:
  - If the last bit of a byte is sampled at edge E, data_out/valid_out/byte_strobe change at edge E+1.
  - If the last COM of the run is sampled at edge E, active rises at E+1.
- Strobe rate: exactly 1 pulse per 8 cycles in ACTIVE, never two in adjacent cycles.
- data_in is sampled continuously; there is no input valid. The TX is responsible for sending COM before data.
- Back-to-back COMs (BCBC...) contain no shifted COM pattern, so SEARCH cannot lock at a false offset on a clean COM stream.

Test Plan:
- Reset release, then 4x COM, first bit sampled at edge 1 -> first detect after edge 8; active=1 after edge 33. Outputs stay 0 and byte_strobe stays 0 before that.
- After lock, send 0xA5 (bits at edges 33..40) then IDL:
  - After edge 41: data_out=8'hA5, valid_out=1, byte_strobe high for 1 cycle.
  - After edge 49: data_out=8'h7C, valid_out=0, strobe pulses again.
- 3 garbage bits (1,0,1), then 4x COM, then 0x3C -> lock at 3-bit offset; active after the 4th COM; 0x3C delivered with valid_out=1.
- 2x COM, 0x55, 4x COM -> active stays 0 through 0x55 (return to SEARCH); active rises only 1 cycle after the last of the final 4 COMs.
- Assert reset mid-byte in ACTIVE -> all outputs 0 immediately (asynchronous). After release, data bytes without COMs never assert active.
- COM_COUNT=1 override, single COM then 0xFF -> active 1 cycle after the COM; 0xFF delivered 8 cycles later with valid_out=1.
